rf_wb_scheduler: RTL and testbench
==================================

# rf_wb_scheduler

Retirement write-back scheduler between the ROB retire stage and the register file write ports. Accepts up to RETIRE_W retiring results per cycle, drops non-writing, x0 and intra-group-superseded results, and buffers the rest in an in-order queue. Drains the queue onto NUM_W_PORTS register file write ports. Also gives issue logic a pending-write lookup, so a source is not read from the regfile while a newer value is still queued.

## Interface
- RETIRE_W, 4: retire slots per cycle; slot 0 is oldest.
- NUM_W_PORTS, 2: regfile write ports driven; 1 ≤ NUM_W_PORTS ≤ RETIRE_W.
- Q_DEPTH, 8: queue entries; power of two, ≥ RETIRE_W.
- SRC_LEN, 5: architectural register index width.
- DATA_LEN, 32: data width.
- NUM_PQ, 4: pending-query ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ret_val  in  RETIRE_W  slot retiring.
- ret_rf_write  in  RETIRE_W  slot writes the regfile.
- ret_rd  in  RETIRE_W×SRC_LEN  destination register.
- ret_data  in  RETIRE_W×DATA_LEN  write-back data.
- ret_ready  out  1  group is accepted this cycle.
- wp_en  out  NUM_W_PORTS  write-port enable.
- wp_addr  out  NUM_W_PORTS×SRC_LEN  write-port address.
- wp_data  out  NUM_W_PORTS×DATA_LEN  write-port data.
- pq_addr  in  NUM_PQ×SRC_LEN  pending-query address.
- pq_hit  out  NUM_PQ  a queued write targets pq_addr.
- q_count  out  $clog2(Q_DEPTH)+1  occupancy.

## Operation
- Filter: slot i is kept when ret_val[i] & ret_rf_write[i] & ret_rd[i]≠0, and no younger kept slot j>i has the same rd.
- Enqueue:
  - Occurs when ret_ready and at least one slot is kept.
  - Kept slots are written compacted, in slot order, at tail.
  - tail and count advance by popcount(kept).
- ret_ready = (Q_DEPTH − q_count) ≥ RETIRE_W. It uses registered count only; no same-cycle dequeue credit.
- If ret_ready=0, the retire group is ignored. The ROB holds it and re-presents it.
- Drain:
  - n = min(q_count, NUM_W_PORTS) oldest entries are presented on ports 0..n−1, oldest on port 0.
  - All presented entries are dequeued at the clock edge of the same cycle.
- Same-cycle duplicate: when two presented entries share an address, wp_en of the older one is 0. The entry is still dequeued. The youngest value wins.
- pq_hit[k]: any valid queue entry has addr == pq_addr[k]. pq_addr=0 always returns 0. Entries being drained this cycle still count as hits.
- Pointers wrap modulo Q_DEPTH. Enqueue and dequeue in the same cycle update count by (enq − deq).

## Timing
- Reset values (async, immediate on rst_n=0):
  - head=tail=0, q_count=0.
  - ret_ready=1, wp_en=0, pq_hit=0.
  - Queue contents are discarded.
  - Reset during a partial drain loses pending writes; the pipeline is flushed by the same reset.
- Latency:
  - A group accepted at edge N appears on wp_* in cycle N→N+1.
  - The regfile write commits at edge N+1.
  - Minimum retire-to-regfile latency is 2 edges.
- wp_*, ret_ready and pq_hit are combinational from registered state plus pq_addr. There is no combinational path from ret_* to any output.
- Full: ret_ready drops when fewer than RETIRE_W entries are free. It rises the cycle after a drain frees enough entries.
- Empty: wp_en=0. A write accepted this cycle is not bypassed to wp_*.
- Throughput: sustained NUM_W_PORTS writes per cycle. Bursts above that are absorbed up to Q_DEPTH.

## Structure
- Shared package (rtl_constants):
  - RETIRE_W default from ROB_MAX_RETIRE.
  - NUM_W_PORTS from NUM_RF_W_PORTS.
  - SRC_LEN, DATA_LEN.
  - typedef rf_wb_entry_t {addr, data}.
- The regfile drops its internal retire-conflict detector and instead takes wp_en/wp_addr/wp_data from this block.
- One sub-module: rf_wb_filter. It is combinational and holds the kept-mask, compaction index and popcount. The queue, pointers and pending CAM stay in the top.

## Test plan
- Reset, then retire slots {rd=3,5,0,7} with all writes valid. Expected:
  - 3 entries enqueued; x0 dropped.
  - Next cycle: port0={3}, port1={5}.
  - Following cycle: port0={7}; q_count 3→1→0.
- Same group with slot0 rd=9 data=A and slot2 rd=9 data=B. Expected: only B is queued; pq_hit(9)=1 until the drain edge.
- Q_DEPTH=8 with 4 writes per cycle for 3 cycles. Expected:
  - Cycle 2 is accepted (count=4 → 6).
  - ret_ready=0 while count>4.
  - Third group is held, then accepted after a drain to count 4.
- Queue holds rd=4 (old, data 1) and then rd=4 (new, data 2), both at the head. Expected: presented together; wp_en[0]=0, wp_en[1]=1 with data 2.
- rst_n asserted mid-burst with q_count=6. Expected: q_count=0, wp_en=0 and ret_ready=1 immediately; no further writes.
- Pointer wrap: run 20 cycles of mixed 1–4 writes. Expected: the wp_* write order matches a reference in-order model exactly.

Source files
------------

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared widths and entry type for the retirement write-back path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_wb_scheduler_pkg;

    // Retire group width of the ROB and number of regfile write ports.
    localparam int ROB_MAX_RETIRE = 4;
    localparam int NUM_RF_W_PORTS = 2;

    // Architectural register index and data widths.
    localparam int SRC_LEN  = 5;
    localparam int DATA_LEN = 32;

    // One pending regfile write: destination register and value.
    typedef struct packed {
        logic [SRC_LEN-1:0]  addr;
        logic [DATA_LEN-1:0] data;
    } rf_wb_entry_t;

endpackage

// File: rtl/rf_wb_filter.sv
// Retire-group filter: kept-mask, compaction index and kept count.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the group is accepted.
module rf_wb_filter
    import rf_wb_scheduler_pkg::*;
#(
    parameter int  RETIRE_W = ROB_MAX_RETIRE,
    localparam int RC_W     = $clog2(RETIRE_W + 1)
) (
    input  logic [RETIRE_W-1:0]               ret_val,
    input  logic [RETIRE_W-1:0]               ret_rf_write,
    input  logic [RETIRE_W-1:0][SRC_LEN-1:0]  ret_rd,
    output logic [RETIRE_W-1:0]               keep,
    output logic [RETIRE_W-1:0][RC_W-1:0]     cidx,
    output logic [RC_W-1:0]                   keep_cnt
);

    logic [RETIRE_W-1:0] cand;
    logic [RC_W-1:0]     run;

    // A slot is a candidate when it really writes a non-x0 register.
    always_comb begin
        cand = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            cand[i] = ret_val[i] & ret_rf_write[i] & (ret_rd[i] != '0);
        end
    end

    // Drop a candidate when a younger candidate in the same group targets
    // the same register; the youngest candidate is always kept, so this is
    // the same as checking against younger kept slots.
    always_comb begin
        keep = cand;
        for (int i = 0; i < RETIRE_W; i++) begin
            for (int j = i + 1; j < RETIRE_W; j++) begin
                if (cand[j] && (ret_rd[j] == ret_rd[i])) begin
                    keep[i] = 1'b0;
                end
            end
        end
    end

    // Exclusive prefix count of kept slots gives each kept slot its offset
    // from the queue tail; the final sum is the enqueue amount.
    always_comb begin
        run  = '0;
        cidx = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            cidx[i] = run;
            run     = run + RC_W'(keep[i]);
        end
        keep_cnt = run;
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Retire write-back scheduler: filters retiring results, queues them in order, drains onto regfile write ports.
// Latency: group accepted at edge N is on wp_* during N..N+1 and commits at edge N+1 (2 edges minimum).
// Backpressure: ret_ready low when fewer than RETIRE_W entries are free (registered count only); group is then ignored.
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
#(
    parameter int RETIRE_W    = ROB_MAX_RETIRE,
    parameter int NUM_W_PORTS = NUM_RF_W_PORTS,
    parameter int Q_DEPTH     = 8,
    parameter int NUM_PQ      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [RETIRE_W-1:0]                   ret_val,
    input  logic [RETIRE_W-1:0]                   ret_rf_write,
    input  logic [RETIRE_W-1:0][SRC_LEN-1:0]      ret_rd,
    input  logic [RETIRE_W-1:0][DATA_LEN-1:0]     ret_data,
    output logic                                  ret_ready,
    output logic [NUM_W_PORTS-1:0]                wp_en,
    output logic [NUM_W_PORTS-1:0][SRC_LEN-1:0]   wp_addr,
    output logic [NUM_W_PORTS-1:0][DATA_LEN-1:0]  wp_data,
    input  logic [NUM_PQ-1:0][SRC_LEN-1:0]        pq_addr,
    output logic [NUM_PQ-1:0]                     pq_hit,
    output logic [$clog2(Q_DEPTH):0]              q_count
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = $clog2(RETIRE_W + 1);

    // Queue storage and pointers. Contents carry no reset: validity is
    // derived purely from head/count, so stale entries are never observed.
    rf_wb_entry_t     q_mem [Q_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    // Filter results for the group currently on ret_*.
    logic [RETIRE_W-1:0]           keep;
    logic [RETIRE_W-1:0][RC_W-1:0] cidx;
    logic [RC_W-1:0]               keep_cnt;

    // Enqueue/dequeue amounts for this cycle.
    logic                          enq;
    logic [CNT_W-1:0]              enq_cnt;
    logic [CNT_W-1:0]              deq_cnt;

    // Head-of-queue window presented to the write ports.
    rf_wb_entry_t [NUM_W_PORTS-1:0] pres_ent;
    logic [NUM_W_PORTS-1:0]         pres_vld;

    // Per-entry validity for the pending-write CAM.
    logic [Q_DEPTH-1:0]             ent_vld;
    logic [PTR_W-1:0]               rel;

    rf_wb_filter #(
        .RETIRE_W (RETIRE_W)
    ) u_filter (
        .ret_val      (ret_val),
        .ret_rf_write (ret_rf_write),
        .ret_rd       (ret_rd),
        .keep         (keep),
        .cidx         (cidx),
        .keep_cnt     (keep_cnt)
    );

    // Acceptance depends only on registered occupancy; a drain in this same
    // cycle does not earn credit, which keeps ret_* off every output path.
    assign ret_ready = (count <= CNT_W'(Q_DEPTH - RETIRE_W));
    assign enq       = ret_ready & (|keep);
    assign enq_cnt   = enq ? CNT_W'(keep_cnt) : '0;
    assign deq_cnt   = (count >= CNT_W'(NUM_W_PORTS)) ? CNT_W'(NUM_W_PORTS) : count;
    assign q_count   = count;

    // Present the oldest min(count, NUM_W_PORTS) entries, oldest on port 0.
    // An older entry is masked when a younger presented entry hits the same
    // register, so the youngest value is the one that lands in the regfile.
    always_comb begin
        pres_ent = '0;
        pres_vld = '0;
        wp_en    = '0;
        wp_addr  = '0;
        wp_data  = '0;
        for (int p = 0; p < NUM_W_PORTS; p++) begin
            pres_ent[p] = q_mem[head + PTR_W'(p)];
            pres_vld[p] = (CNT_W'(p) < count);
        end
        for (int p = 0; p < NUM_W_PORTS; p++) begin
            wp_en[p] = pres_vld[p];
            for (int j = p + 1; j < NUM_W_PORTS; j++) begin
                if (pres_vld[j] && (pres_ent[j].addr == pres_ent[p].addr)) begin
                    wp_en[p] = 1'b0;
                end
            end
            if (pres_vld[p]) begin
                wp_addr[p] = pres_ent[p].addr;
                wp_data[p] = pres_ent[p].data;
            end
        end
    end

    // An entry is live when its distance from head is below the occupancy;
    // the pointer subtraction wraps naturally because Q_DEPTH is a power of two.
    always_comb begin
        rel     = '0;
        ent_vld = '0;
        for (int e = 0; e < Q_DEPTH; e++) begin
            rel        = PTR_W'(e) - head;
            ent_vld[e] = (CNT_W'(rel) < count);
        end
    end

    // Pending-write lookup over all live entries, including those being
    // drained this cycle (their write has not committed yet). x0 never hits.
    always_comb begin
        pq_hit = '0;
        for (int k = 0; k < NUM_PQ; k++) begin
            if (pq_addr[k] != '0) begin
                for (int e = 0; e < Q_DEPTH; e++) begin
                    if (ent_vld[e] && (q_mem[e].addr == pq_addr[k])) begin
                        pq_hit[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Pointer and occupancy update; enqueue and dequeue may share a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_cnt);
            tail  <= tail + PTR_W'(enq_cnt);
            count <= count + enq_cnt - deq_cnt;
        end
    end

    // Write kept slots compacted at the tail in slot order.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < RETIRE_W; i++) begin
                if (keep[i]) begin
                    q_mem[tail + PTR_W'(cidx[i])] <= '{addr: ret_rd[i], data: ret_data[i]};
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: scenario tasks plus an in-order scoreboard.
// Latency: expected writes are pushed when a group is accepted and popped when presented.
// Backpressure: the retire task re-presents a group until the bench's own occupancy model says it is accepted.
`timescale 1ns/1ps
module tb_rf_wb_scheduler;
    import rf_wb_scheduler_pkg::*;

    localparam int RW  = 4;
    localparam int NW  = 2;
    localparam int QD  = 8;
    localparam int NPQ = 4;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [RW-1:0]                ret_val = '0;
    logic [RW-1:0]                ret_rf_write = '0;
    logic [RW-1:0][SRC_LEN-1:0]   ret_rd = '0;
    logic [RW-1:0][DATA_LEN-1:0]  ret_data = '0;
    logic                         ret_ready;
    logic [NW-1:0]                wp_en;
    logic [NW-1:0][SRC_LEN-1:0]   wp_addr;
    logic [NW-1:0][DATA_LEN-1:0]  wp_data;
    logic [NPQ-1:0][SRC_LEN-1:0]  pq_addr = '0;
    logic [NPQ-1:0]               pq_hit;
    logic [3:0]                   q_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [SRC_LEN-1:0]  a;
        logic [DATA_LEN-1:0] d;
    } ent_t;

    ent_t model_q[$];
    ent_t pend_q[$];
    logic last_acc = 1'b0;
    logic sb_on = 1'b0;
    int   mon_size;
    int   mon_n;
    logic mon_exp_rdy;
    logic mon_exp_en;
    logic mon_exp_hit;

    rf_wb_scheduler #(
        .RETIRE_W    (RW),
        .NUM_W_PORTS (NW),
        .Q_DEPTH     (QD),
        .NUM_PQ      (NPQ)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ret_val      (ret_val),
        .ret_rf_write (ret_rf_write),
        .ret_rd       (ret_rd),
        .ret_data     (ret_data),
        .ret_ready    (ret_ready),
        .wp_en        (wp_en),
        .wp_addr      (wp_addr),
        .wp_data      (wp_data),
        .pq_addr      (pq_addr),
        .pq_hit       (pq_hit),
        .q_count      (q_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    // Scoreboard: on each falling edge compare the presented writes, pending
    // lookups, occupancy and ready against the reference queue, then retire
    // the presented entries and append the group accepted this cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            last_acc = 1'b0;
        end else if (sb_on) begin
            mon_size    = model_q.size();
            mon_exp_rdy = ((QD - mon_size) >= RW);
            checks++;
            if (ret_ready !== mon_exp_rdy) begin
                errors++;
                $display("FAIL sb_ret_ready t=%0t got=%b exp=%b", $time, ret_ready, mon_exp_rdy);
            end
            checks++;
            if (q_count !== 4'(mon_size)) begin
                errors++;
                $display("FAIL sb_q_count t=%0t got=%0d exp=%0d", $time, q_count, mon_size);
            end
            for (int k = 0; k < NPQ; k++) begin
                mon_exp_hit = 1'b0;
                if (pq_addr[k] != '0) begin
                    foreach (model_q[e]) if (model_q[e].a == pq_addr[k]) mon_exp_hit = 1'b1;
                end
                checks++;
                if (pq_hit[k] !== mon_exp_hit) begin
                    errors++;
                    $display("FAIL sb_pq_hit t=%0t k=%0d addr=%0d got=%b exp=%b", $time, k, pq_addr[k], pq_hit[k], mon_exp_hit);
                end
            end
            mon_n = (mon_size < NW) ? mon_size : NW;
            for (int p = 0; p < NW; p++) begin
                mon_exp_en = (p < mon_n);
                for (int j = p + 1; j < mon_n; j++) begin
                    if (model_q[j].a == model_q[p].a) mon_exp_en = 1'b0;
                end
                checks++;
                if (wp_en[p] !== mon_exp_en) begin
                    errors++;
                    $display("FAIL sb_wp_en t=%0t port=%0d got=%b exp=%b", $time, p, wp_en[p], mon_exp_en);
                end
                if (mon_exp_en) begin
                    checks++;
                    if (wp_addr[p] !== model_q[p].a || wp_data[p] !== model_q[p].d) begin
                        errors++;
                        $display("FAIL sb_wp_write t=%0t port=%0d got=%0d/%h exp=%0d/%h",
                                 $time, p, wp_addr[p], wp_data[p], model_q[p].a, model_q[p].d);
                    end
                end
            end
            for (int p = 0; p < mon_n; p++) void'(model_q.pop_front());
            last_acc = mon_exp_rdy;
            if (mon_exp_rdy) begin
                foreach (pend_q[i]) model_q.push_back(pend_q[i]);
            end
        end
    end

    // Drive one retire group (called just after a rising edge), hold it until
    // accepted, and report how many cycles it was held.
    task automatic retire(input logic [RW-1:0] v, input logic [RW-1:0] w,
                          input logic [RW-1:0][SRC_LEN-1:0] rd,
                          input logic [RW-1:0][DATA_LEN-1:0] d, output int waits);
        ent_t e;
        bit   sup;
        pend_q.delete();
        for (int i = 0; i < RW; i++) begin
            if (v[i] && w[i] && rd[i] != '0) begin
                sup = 1'b0;
                for (int j = i + 1; j < RW; j++) begin
                    if (v[j] && w[j] && rd[j] == rd[i]) sup = 1'b1;
                end
                if (!sup) begin
                    e.a = rd[i];
                    e.d = d[i];
                    pend_q.push_back(e);
                end
            end
        end
        ret_val      = v;
        ret_rf_write = w;
        ret_rd       = rd;
        ret_data     = d;
        waits        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (last_acc) break;
            waits++;
            if (waits > 20) begin
                checks++;
                errors++;
                $display("FAIL retire_timeout t=%0t held=%0d cycles limit=20", $time, waits);
                break;
            end
        end
        ret_val      = '0;
        ret_rf_write = '0;
        pend_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (q_count !== 4'd0)  begin errors++; $display("FAIL reset_count got=%0d exp=0", q_count); end
        checks++; if (ret_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ret_ready); end
        checks++; if (wp_en !== 2'b00)    begin errors++; $display("FAIL reset_wp_en got=%b exp=00", wp_en); end
        checks++; if (pq_hit !== 4'b0000) begin errors++; $display("FAIL reset_pq_hit got=%b exp=0000", pq_hit); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb_on = 1'b1;
    endtask

    task automatic test_basic();
        int waits;
        pq_addr[0] = 5'd3; pq_addr[1] = 5'd5; pq_addr[2] = 5'd7; pq_addr[3] = 5'd0;
        retire(4'hF, 4'hF, {5'd7, 5'd0, 5'd5, 5'd3}, {32'h77, 32'h0, 32'h55, 32'h33}, waits);
        checks++; if (q_count !== 4'd3) begin errors++; $display("FAIL basic_count1 got=%0d exp=3", q_count); end
        checks++; if (wp_en !== 2'b11)  begin errors++; $display("FAIL basic_en1 got=%b exp=11", wp_en); end
        checks++; if (wp_addr[0] !== 5'd3 || wp_addr[1] !== 5'd5) begin
            errors++; $display("FAIL basic_addr1 got=%0d,%0d exp=3,5", wp_addr[0], wp_addr[1]); end
        checks++; if (wp_data[0] !== 32'h33) begin errors++; $display("FAIL basic_data0 got=%h exp=33", wp_data[0]); end
        checks++; if (pq_hit !== 4'b0111) begin errors++; $display("FAIL basic_hit1 got=%b exp=0111", pq_hit); end
        idle(1);
        checks++; if (q_count !== 4'd1) begin errors++; $display("FAIL basic_count2 got=%0d exp=1", q_count); end
        checks++; if (wp_en !== 2'b01 || wp_addr[0] !== 5'd7) begin
            errors++; $display("FAIL basic_port2 got=%b/%0d exp=01/7", wp_en, wp_addr[0]); end
        checks++; if (pq_hit !== 4'b0100) begin errors++; $display("FAIL basic_hit2 got=%b exp=0100", pq_hit); end
        idle(1);
        checks++; if (q_count !== 4'd0 || wp_en !== 2'b00) begin
            errors++; $display("FAIL basic_empty got=%0d/%b exp=0/00", q_count, wp_en); end
    endtask

    task automatic test_intra_group_dup();
        int waits;
        pq_addr[0] = 5'd9; pq_addr[1] = 5'd0; pq_addr[2] = 5'd5; pq_addr[3] = 5'd7;
        retire(4'hF, 4'hF, {5'd7, 5'd9, 5'd5, 5'd9},
               {32'h70, 32'hBBBB_0002, 32'h50, 32'hAAAA_0001}, waits);
        checks++; if (q_count !== 4'd3) begin errors++; $display("FAIL dup_count got=%0d exp=3", q_count); end
        checks++; if (pq_hit[0] !== 1'b1) begin errors++; $display("FAIL dup_hit9_pre got=%b exp=1", pq_hit[0]); end
        checks++; if (pq_hit[1] !== 1'b0) begin errors++; $display("FAIL dup_hit_x0 got=%b exp=0", pq_hit[1]); end
        checks++; if (wp_addr[1] !== 5'd9 || wp_data[1] !== 32'hBBBB_0002) begin
            errors++; $display("FAIL dup_port1 got=%0d/%h exp=9/bbbb0002", wp_addr[1], wp_data[1]); end
        idle(1);
        checks++; if (pq_hit[0] !== 1'b0) begin errors++; $display("FAIL dup_hit9_post got=%b exp=0", pq_hit[0]); end
        idle(1);
    endtask

    task automatic test_full();
        int waits;
        pq_addr = '0;
        retire(4'hF, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h4, 32'h3, 32'h2, 32'h1}, waits);
        checks++; if (q_count !== 4'd4 || ret_ready !== 1'b1) begin
            errors++; $display("FAIL full_g1 got=%0d/%b exp=4/1", q_count, ret_ready); end
        retire(4'hF, 4'hF, {5'd8, 5'd7, 5'd6, 5'd5}, {32'h8, 32'h7, 32'h6, 32'h5}, waits);
        checks++; if (q_count !== 4'd6 || ret_ready !== 1'b0) begin
            errors++; $display("FAIL full_g2 got=%0d/%b exp=6/0", q_count, ret_ready); end
        retire(4'hF, 4'hF, {5'd12, 5'd11, 5'd10, 5'd9}, {32'hC, 32'hB, 32'hA, 32'h9}, waits);
        checks++; if (waits !== 1) begin errors++; $display("FAIL full_hold got=%0d exp=1", waits); end
        checks++; if (q_count !== 4'd6) begin errors++; $display("FAIL full_g3 got=%0d exp=6", q_count); end
        idle(4);
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL full_drain got=%0d exp=0", q_count); end
    endtask

    task automatic test_same_addr_head();
        int waits;
        retire(4'b0111, 4'b0111, {5'd0, 5'd4, 5'd11, 5'd10}, {32'h0, 32'h1, 32'h11, 32'h10}, waits);
        checks++; if (q_count !== 4'd3) begin errors++; $display("FAIL head_count1 got=%0d exp=3", q_count); end
        retire(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h0, 32'h2}, waits);
        checks++; if (q_count !== 4'd2) begin errors++; $display("FAIL head_count2 got=%0d exp=2", q_count); end
        checks++; if (wp_en !== 2'b10) begin errors++; $display("FAIL head_en got=%b exp=10", wp_en); end
        checks++; if (wp_addr[1] !== 5'd4 || wp_data[1] !== 32'h2) begin
            errors++; $display("FAIL head_port1 got=%0d/%h exp=4/2", wp_addr[1], wp_data[1]); end
        idle(1);
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL head_empty got=%0d exp=0", q_count); end
    endtask

    task automatic test_reset_mid_burst();
        int waits;
        pq_addr[0] = 5'd7;
        retire(4'hF, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h4, 32'h3, 32'h2, 32'h1}, waits);
        retire(4'hF, 4'hF, {5'd8, 5'd7, 5'd6, 5'd5}, {32'h8, 32'h7, 32'h6, 32'h5}, waits);
        checks++; if (q_count !== 4'd6) begin errors++; $display("FAIL rstmid_pre got=%0d exp=6", q_count); end
        #2;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", q_count); end
        checks++; if (wp_en !== 2'b00) begin errors++; $display("FAIL rstmid_en got=%b exp=00", wp_en); end
        checks++; if (ret_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", ret_ready); end
        checks++; if (pq_hit !== 4'b0000) begin errors++; $display("FAIL rstmid_hit got=%b exp=0000", pq_hit); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        checks++; if (wp_en !== 2'b00 || q_count !== 4'd0) begin
            errors++; $display("FAIL rstmid_after got=%b/%0d exp=00/0", wp_en, q_count); end
    endtask

    task automatic test_wrap();
        int waits;
        int k;
        logic [RW-1:0]               v;
        logic [RW-1:0][SRC_LEN-1:0]  rd;
        logic [RW-1:0][DATA_LEN-1:0] d;
        pq_addr[0] = 5'd1; pq_addr[1] = 5'd2; pq_addr[2] = 5'd6; pq_addr[3] = 5'd11;
        for (int c = 0; c < 20; c++) begin
            k = int'($urandom_range(1, 4));
            v = 4'((1 << k) - 1);
            for (int i = 0; i < RW; i++) begin
                rd[i] = 5'($urandom_range(1, 12));
                d[i]  = $urandom;
            end
            retire(v, v, rd, d, waits);
        end
        idle(10);
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL wrap_drain got=%0d exp=0", q_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_intra_group_dup();
        test_full();
        test_same_addr_head();
        test_reset_mid_burst();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
